// File: rtl/dffn_chain_bist_pkg.sv
// Shared types and constant helpers for the negedge-flop chain BIST controller.
// Used by dffn_chain_bist and dffn_chain_bist_lfsr.
package dffn_chain_bist_pkg;

    typedef enum logic [1:0] {
        ModeZero = 2'd0,
        ModeOne  = 2'd1,
        ModeChk  = 2'd2,
        ModeLfsr = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Maximal-length Galois (right-shift) feedback masks, widths 2..32.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Checkerboard seed word with LSB set; callers truncate to their width.
    function automatic logic [31:0] chk_pattern(input int unsigned w);
        return (w > 0) ? 32'h5555_5555 : 32'h0;
    endfunction

endpackage

// File: rtl/dffn_chain_bist_lfsr.sv
// Galois LFSR pattern source for the BIST controller; a zero seed is replaced by 1
// so the register can never lock up.
module dffn_chain_bist_lfsr
    import dffn_chain_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] SEED  = 32'h0000_00A5
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] Taps    = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SeedRaw = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SeedEff = (SeedRaw == '0) ? WIDTH'(1) : SeedRaw;

    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = {1'b0, value[WIDTH-1:1]} ^ (value[0] ? Taps : '0);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            value <= SeedEff;
        end else if (load) begin
            value <= SeedEff;
        end else if (advance) begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/dffn_chain_bist.sv
// BIST controller for a bank of negedge D flops: drives patterns, compares returned Q against a
// LAT-deep expected pipe. Optional first-fail capture under DFFN_CHAIN_BIST_FIRST_FAIL_EN.
module dffn_chain_bist
    import dffn_chain_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 1,
    parameter int unsigned NVEC  = 256,
    parameter logic [31:0] SEED  = 32'h0000_00A5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] D_OUT,
    input  logic [WIDTH-1:0] Q_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT
`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
    ,
    output logic [15:0]      FAIL_IDX,
    output logic [WIDTH-1:0] FAIL_SYN
`endif
);

    localparam int unsigned      IW        = $clog2(NVEC + 1);
    localparam logic [IW-1:0]    LastIdx   = IW'(NVEC - 1);
    localparam logic [3:0]       DrainLast = 4'(LAT - 1);
    localparam logic [WIDTH-1:0] Chk       = WIDTH'(chk_pattern(WIDTH));

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [IW-1:0]    idx_q;
    logic [3:0]       drain_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q;
    logic [WIDTH:0]   pipe_q [LAT];
    logic [WIDTH-1:0] lfsr_val, vec, exp_val;
    logic             start_ok, issue, cmp_valid, mismatch;

    assign start_ok  = START && (state_q == StIdle || state_q == StDone);
    assign issue     = (state_q == StRun);
    assign cmp_valid = pipe_q[LAT-1][WIDTH];
    assign exp_val   = pipe_q[LAT-1][WIDTH-1:0];
    assign mismatch  = cmp_valid && (Q_IN != exp_val);

    dffn_chain_bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RN      (RN),
        .load    (start_ok),
        .advance (issue),
        .value   (lfsr_val)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = StRun;
            StRun:   if (idx_q == LastIdx) state_d = StDrain;
            StDrain: if (drain_q == DrainLast) state_d = StDone;
            StDone:  if (START) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vec = '0;
        unique case (mode_q)
            ModeZero: vec = '0;
            ModeOne:  vec = '1;
            ModeChk:  vec = idx_q[0] ? ~Chk : Chk;
            ModeLfsr: vec = lfsr_val;
            default:  vec = '0;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_ok) begin
            err_cnt_d = '0;
        end else if (mismatch && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= StIdle;
            mode_q    <= ModeZero;
            idx_q     <= '0;
            drain_q   <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            drain_q   <= (state_q == StDrain) ? drain_q + 4'd1 : 4'd0;
            if (start_ok) begin
                mode_q <= mode_e'(MODE);
                idx_q  <= '0;
                pass_q <= 1'b0;
                for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
            end else begin
                if (issue) idx_q <= idx_q + IW'(1);
                if (state_q == StDrain && state_d == StDone) pass_q <= (err_cnt_d == '0);
                // Stage 0 doubles as the D_OUT register, so D_OUT is 0 whenever nothing issues.
                pipe_q[0] <= issue ? {1'b1, vec} : '0;
                for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign D_OUT   = pipe_q[0][WIDTH-1:0];
    assign BUSY    = (state_q == StRun) || (state_q == StDrain);
    assign DONE    = (state_q == StDone);
    assign PASS    = pass_q;
    assign ERR_CNT = err_cnt_q;

`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
    logic [15:0] cmp_idx_q;
    logic        fail_seen_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cmp_idx_q   <= '0;
            fail_seen_q <= 1'b0;
            FAIL_IDX    <= '0;
            FAIL_SYN    <= '0;
        end else if (start_ok) begin
            cmp_idx_q   <= '0;
            fail_seen_q <= 1'b0;
            FAIL_IDX    <= '0;
            FAIL_SYN    <= '0;
        end else if (cmp_valid) begin
            cmp_idx_q <= cmp_idx_q + 16'd1;
            if (mismatch && !fail_seen_q) begin
                fail_seen_q <= 1'b1;
                FAIL_IDX    <= cmp_idx_q;
                FAIL_SYN    <= Q_IN ^ exp_val;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dffn_chain_bist.sv
// Directed self-checking bench for dffn_chain_bist: default, saturating (CNT_W=4) and LAT=3
// instances, each fed by a behavioural negedge flop model.
module tb_dffn_chain_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn;
    int   checks = 0;
    int   errors = 0;

    // Default instance: WIDTH=8, LAT=1, NVEC=256.
    logic       start;
    logic [1:0] mode;
    logic [7:0] d_out, q_flop, force1, flip, q_in;
    logic       busy, done, pass;
    logic [15:0] err_cnt;
    assign q_in = (q_flop | force1) ^ flip;
    always @(negedge clk) q_flop <= d_out;

    // Saturation instance: CNT_W=4, NVEC=32, all-zero pattern against all-ones Q.
    logic       start_s;
    logic [1:0] mode_s = 2'd0;
    logic [7:0] d_out_s;
    logic [7:0] q_in_s = 8'hFF;
    logic       busy_s, done_s, pass_s;
    logic [3:0] err_s;

    // Latency-3 instance: three negedge flops in series.
    logic       start_3;
    logic [1:0] mode_3 = 2'd3;
    logic [7:0] d_out_3, c1, c2, c3;
    logic       busy_3, done_3, pass_3;
    logic [15:0] err_3;
    always @(negedge clk) begin
        c1 <= d_out_3;
        c2 <= c1;
        c3 <= c2;
    end

`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
    logic [15:0] fail_idx, fail_idx_s, fail_idx_3;
    logic [7:0]  fail_syn, fail_syn_s, fail_syn_3;
`endif

    dffn_chain_bist u_dut (
        .CLK(clk), .RN(rn), .START(start), .MODE(mode), .D_OUT(d_out), .Q_IN(q_in),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt)
`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
        , .FAIL_IDX(fail_idx), .FAIL_SYN(fail_syn)
`endif
    );

    dffn_chain_bist #(.NVEC(32), .CNT_W(4)) u_dut_sat (
        .CLK(clk), .RN(rn), .START(start_s), .MODE(mode_s), .D_OUT(d_out_s), .Q_IN(q_in_s),
        .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .ERR_CNT(err_s)
`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
        , .FAIL_IDX(fail_idx_s), .FAIL_SYN(fail_syn_s)
`endif
    );

    dffn_chain_bist #(.LAT(3), .NVEC(16)) u_dut_lat3 (
        .CLK(clk), .RN(rn), .START(start_3), .MODE(mode_3), .D_OUT(d_out_3), .Q_IN(c3),
        .BUSY(busy_3), .DONE(done_3), .PASS(pass_3), .ERR_CNT(err_3)
`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
        , .FAIL_IDX(fail_idx_3), .FAIL_SYN(fail_syn_3)
`endif
    );

    // Pulse START through the posedge that samples it; returns 1ns after that edge.
    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts posedges after the START edge until DONE, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int bad;
        rn      = 1'b0;
        start   = 1'($urandom);
        mode    = 2'($urandom);
        force1  = 8'($urandom);
        flip    = 8'($urandom);
        start_s = 1'($urandom);
        start_3 = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out: got %h expected 00", d_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        checks++; if ({busy_s, done_s, err_s, busy_3, done_3} !== 8'd0) begin
            errors++; $display("FAIL reset_others: got %h expected 00", {busy_s, done_s, err_s, busy_3, done_3});
        end
        start   = 1'b0;
        start_s = 1'b0;
        start_3 = 1'b0;
        force1  = 8'h00;
        flip    = 8'h00;
        @(negedge clk);
        rn = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_hold: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_lfsr_ideal();
        logic [7:0] lm;
        int bad_seq, zeros;
        pulse_start(2'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b expected 1", busy); end
        lm = 8'hA5;
        bad_seq = 0;
        zeros = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            if (d_out !== lm) bad_seq++;
            if (d_out == 8'h00) zeros++;
            lm = lm[0] ? ((lm >> 1) ^ 8'hB8) : (lm >> 1);
        end
        checks++; if (bad_seq != 0) begin errors++; $display("FAIL lfsr_seq: got %0d wrong vectors expected 0", bad_seq); end
        checks++; if (zeros != 0) begin errors++; $display("FAIL lfsr_nonzero: got %0d zero vectors expected 0", zeros); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL drain_state: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_timing: got %b expected 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %b expected 1", pass); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL ideal_err: got %0d expected 0", err_cnt); end
        checks++; if (d_out !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL done_idle_out: got d_out=%h busy=%b expected 00/0", d_out, busy);
        end
    endtask

    task automatic test_stuck_at();
        int cyc;
        force1 = 8'h08;
        pulse_start(2'd0);
        wait_done(cyc);
        checks++; if (cyc != 257) begin errors++; $display("FAIL stuck0_cycles: got %0d expected 257", cyc); end
        checks++; if (err_cnt !== 16'd256) begin errors++; $display("FAIL stuck0_err: got %0d expected 256", err_cnt); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck0_pass: got %b expected 0", pass); end
        pulse_start(2'd1);
        checks++; if (done !== 1'b0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL restart_clear: got done=%b err=%0d expected 0/0", done, err_cnt);
        end
        wait_done(cyc);
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL stuck1_err: got %0d expected 0", err_cnt); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL stuck1_pass: got %b expected 1", pass); end
        force1 = 8'h00;
    endtask

    task automatic test_checkerboard();
        int cyc;
        pulse_start(2'd2);
        @(posedge clk); #1;
        checks++; if (d_out !== 8'h55) begin errors++; $display("FAIL chk_vec0: got %h expected 55", d_out); end
        @(posedge clk); #1;
        checks++; if (d_out !== 8'hAA) begin errors++; $display("FAIL chk_vec1: got %h expected aa", d_out); end
        // Vector 17 sits on D_OUT after the 18th edge and is compared on the 19th.
        repeat (16) @(posedge clk);
        #1 flip = 8'h10;
        @(posedge clk);
        #1 flip = 8'h00;
        wait_done(cyc);
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL chk_err: got %0d expected 1", err_cnt); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL chk_pass: got %b expected 0", pass); end
`ifdef DFFN_CHAIN_BIST_FIRST_FAIL_EN
        checks++; if (fail_idx !== 16'd17) begin errors++; $display("FAIL fail_idx: got %0d expected 17", fail_idx); end
        checks++; if (fail_syn !== 8'h10) begin errors++; $display("FAIL fail_syn: got %h expected 10", fail_syn); end
`endif
    endtask

    task automatic test_saturation();
        int cyc;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (err_s !== 4'd15) begin errors++; $display("FAIL sat_mid: got %0d expected 15", err_s); end
        cyc = 20;
        while (done_s !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc != 33) begin errors++; $display("FAIL sat_cycles: got %0d expected 33", cyc); end
        checks++; if (err_s !== 4'd15) begin errors++; $display("FAIL sat_end: got %0d expected 15", err_s); end
        checks++; if (pass_s !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", pass_s); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (err_s !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", err_s); end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        force1 = 8'h01;
        pulse_start(2'd0);
        repeat (101) @(posedge clk);
        #1;
        checks++; if (err_cnt !== 16'd100) begin errors++; $display("FAIL pre_reset_err: got %0d expected 100", err_cnt); end
        rn = 1'b0;
        #1;
        checks++; if (err_cnt !== 16'd0 || busy !== 1'b0 || d_out !== 8'h00 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: got err=%0d busy=%b d_out=%h done=%b expected 0", err_cnt, busy, d_out, done);
        end
        @(negedge clk);
        rn = 1'b1;
        force1 = 8'h00;
        pulse_start(2'd3);
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc);
        cyc = cyc + 51;
        checks++; if (cyc != 257) begin errors++; $display("FAIL start_ignored: got %0d cycles expected 257", cyc); end
        checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL rerun_pass: got pass=%b err=%0d expected 1/0", pass, err_cnt);
        end
    endtask

    task automatic test_lat3();
        int cyc;
        @(posedge clk); #1 start_3 = 1'b1;
        @(posedge clk); #1 start_3 = 1'b0;
        cyc = 0;
        while (done_3 !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc != 19) begin errors++; $display("FAIL lat3_cycles: got %0d expected 19", cyc); end
        checks++; if (pass_3 !== 1'b1 || err_3 !== 16'd0) begin
            errors++; $display("FAIL lat3_pass: got pass=%b err=%0d expected 1/0", pass_3, err_3);
        end
    endtask

    initial begin
        rn      = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        start_3 = 1'b0;
        mode    = 2'd0;
        force1  = 8'h00;
        flip    = 8'h00;
        test_reset();
        test_lfsr_ideal();
        test_stuck_at();
        test_checkerboard();
        test_saturation();
        test_reset_midrun();
        test_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
